// File: rtl/layer_compositor.sv
// Two-stage sprite layer compositor: priority mux over NUM_LAYERS layers with frame-synchronous layer masking.
// Define COMPOSITOR_COLLISION_EN to build in per-frame collision detection between layer sets A and B.
module layer_compositor #(
    parameter int                    NUM_LAYERS  = 8,
    parameter int                    COLOR_W     = 16,
    parameter logic [NUM_LAYERS-1:0] COLL_MASK_A = 'h02,
    parameter logic [NUM_LAYERS-1:0] COLL_MASK_B = 'h04
) (
    input  logic                            clk,
    input  logic                            rst,
    input  logic                            raw_hsync,
    input  logic                            raw_vsync,
    input  logic                            raw_de,
    input  logic                            new_frame,
    input  logic [COLOR_W-1:0]              bg_color,
    input  logic [NUM_LAYERS-1:0]           layer_pe,
    input  logic [NUM_LAYERS*COLOR_W-1:0]   layer_color,
    input  logic [NUM_LAYERS-1:0]           cfg_mask,
    input  logic                            cfg_wr,
    output logic                            vga_hsync,
    output logic                            vga_vsync,
    output logic                            vga_de,
    output logic [COLOR_W-1:0]              vga_rgb,
    output logic [3:0]                      hit_layer,
    output logic                            collision
);

    logic [NUM_LAYERS-1:0]         pending_mask;
    logic [NUM_LAYERS-1:0]         active_mask;
    logic [NUM_LAYERS-1:0]         masked_pe;

    logic                          s1_hsync;
    logic                          s1_vsync;
    logic                          s1_de;
    logic [COLOR_W-1:0]            s1_bg;
    logic [NUM_LAYERS*COLOR_W-1:0] s1_color;
    logic [NUM_LAYERS-1:0]         s1_pe;

    logic [3:0]                    sel_idx;
    logic [COLOR_W-1:0]            sel_color;

    assign masked_pe = layer_pe & active_mask;

    // Mask writes only take effect at a frame boundary; a write coinciding with new_frame goes straight to active.
    always_ff @(posedge clk) begin
        if (rst) begin
            pending_mask <= '1;
            active_mask  <= '1;
        end else begin
            if (cfg_wr) begin
                pending_mask <= cfg_mask;
            end
            if (new_frame) begin
                active_mask <= cfg_wr ? cfg_mask : pending_mask;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            s1_hsync <= 1'b0;
            s1_vsync <= 1'b0;
            s1_de    <= 1'b0;
            s1_bg    <= '0;
            s1_color <= '0;
            s1_pe    <= '0;
        end else begin
            s1_hsync <= raw_hsync;
            s1_vsync <= raw_vsync;
            s1_de    <= raw_de;
            s1_bg    <= bg_color;
            s1_color <= layer_color;
            s1_pe    <= masked_pe;
        end
    end

    // Ascending scan so the highest-index painting layer overrides lower ones.
    always_comb begin
        sel_idx   = 4'hF;
        sel_color = s1_bg;
        for (int i = 0; i < NUM_LAYERS; i++) begin
            if (s1_pe[i]) begin
                sel_idx   = 4'(i);
                sel_color = s1_color[i*COLOR_W +: COLOR_W];
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            vga_hsync <= 1'b0;
            vga_vsync <= 1'b0;
            vga_de    <= 1'b0;
            vga_rgb   <= '0;
            hit_layer <= 4'hF;
        end else begin
            vga_hsync <= s1_hsync;
            vga_vsync <= s1_vsync;
            vga_de    <= s1_de;
            if (s1_de) begin
                vga_rgb   <= sel_color;
                hit_layer <= sel_idx;
            end else begin
                vga_rgb   <= '0;
                hit_layer <= 4'hF;
            end
        end
    end

`ifdef COMPOSITOR_COLLISION_EN
    logic coll_accum;
    logic pixel_hit;

    assign pixel_hit = raw_de && (|(masked_pe & COLL_MASK_A)) && (|(masked_pe & COLL_MASK_B));

    // A hit on the new_frame cycle itself seeds the accumulator for the frame that is starting.
    always_ff @(posedge clk) begin
        if (rst) begin
            coll_accum <= 1'b0;
            collision  <= 1'b0;
        end else if (new_frame) begin
            collision  <= coll_accum;
            coll_accum <= pixel_hit;
        end else begin
            collision  <= 1'b0;
            coll_accum <= coll_accum | pixel_hit;
        end
    end
`else
    // The collision masks stay referenced so the parameter list means the same in both builds.
    localparam logic COLL_MASKS_SET = |{COLL_MASK_A, COLL_MASK_B};
    assign collision = 1'b0 && COLL_MASKS_SET;
`endif

endmodule

// File: tb/tb_layer_compositor.sv
// Randomised scoreboard bench for layer_compositor: a per-edge behavioural model queues expected outputs,
// a negedge monitor pops and compares them. Honours COMPOSITOR_COLLISION_EN like the design.
module tb_layer_compositor;

    localparam int NL = 8;
    localparam int CW = 16;

    logic            clk = 1'b0;
    logic            rst;
    logic            raw_hsync, raw_vsync, raw_de, new_frame, cfg_wr;
    logic [CW-1:0]   bg_color;
    logic [NL-1:0]   layer_pe, cfg_mask;
    logic [NL*CW-1:0] layer_color;
    logic            vga_hsync, vga_vsync, vga_de, collision;
    logic [CW-1:0]   vga_rgb;
    logic [3:0]      hit_layer;

    layer_compositor #(.NUM_LAYERS(NL), .COLOR_W(CW), .COLL_MASK_A(8'h02), .COLL_MASK_B(8'h04)) dut (
        .clk(clk), .rst(rst),
        .raw_hsync(raw_hsync), .raw_vsync(raw_vsync), .raw_de(raw_de),
        .new_frame(new_frame), .bg_color(bg_color),
        .layer_pe(layer_pe), .layer_color(layer_color),
        .cfg_mask(cfg_mask), .cfg_wr(cfg_wr),
        .vga_hsync(vga_hsync), .vga_vsync(vga_vsync), .vga_de(vga_de),
        .vga_rgb(vga_rgb), .hit_layer(hit_layer), .collision(collision)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic           rst;
        logic           hs, vs, de;
        logic [CW-1:0]  bg;
        logic [NL-1:0]  pe_m;
        logic [NL*CW-1:0] col;
    } stim_t;

    typedef struct {
        int             target;
        logic           hs, vs, de, coll;
        logic [CW-1:0]  rgb;
        logic [3:0]     hit;
    } exp_t;

    exp_t   exp_q[$];
    int     cyc = 0;
    int     checks_total = 0;
    int     checks_passed = 0;
    int     coll_pulses_expected = 0;

    logic [NL-1:0] m_active = '1;
    logic [NL-1:0] m_pending = '1;
    logic          m_accum = 1'b0;
    stim_t         prev = '{rst: 1'b1, hs: 1'b0, vs: 1'b0, de: 1'b0, bg: '0, pe_m: '0, col: '0};

    always @(posedge clk) cyc <= cyc + 1;

    task automatic compareField(input string name, input int t, input logic [CW-1:0] got, input logic [CW-1:0] want);
        checks_total++;
        if (got === want) begin
            checks_passed++;
        end else begin
            $display("[TB] FAIL %s at cycle %0d: got %h, expected %h", name, t, got, want);
        end
    endtask

    task automatic checkOutput(input exp_t e);
        compareField("vga_hsync", e.target, CW'(vga_hsync), CW'(e.hs));
        compareField("vga_vsync", e.target, CW'(vga_vsync), CW'(e.vs));
        compareField("vga_de",    e.target, CW'(vga_de),    CW'(e.de));
        compareField("vga_rgb",   e.target, vga_rgb,        e.rgb);
        compareField("hit_layer", e.target, CW'(hit_layer), CW'(e.hit));
        compareField("collision", e.target, CW'(collision), CW'(e.coll));
    endtask

    always @(negedge clk) begin
        while (exp_q.size() != 0 && exp_q[0].target < cyc) begin
            checks_total++;
            $display("[TB] FAIL stale_expectation target %0d at cycle %0d: got no check, expected one", exp_q[0].target, cyc);
            void'(exp_q.pop_front());
        end
        if (exp_q.size() != 0 && exp_q[0].target == cyc) begin
            checkOutput(exp_q.pop_front());
        end
    end

    // Drives one cycle of inputs, predicts the outputs visible right after the coming edge, then advances.
    task automatic applyStimulus(input logic r, input logic nf, input logic wr, input logic [NL-1:0] cfg,
                                 input logic de, input logic hs, input logic vs,
                                 input logic [NL-1:0] pe, input logic [CW-1:0] bg, input logic [NL*CW-1:0] col);
        exp_t          e;
        stim_t         cur;
        logic [NL-1:0] masked;
        logic          hit_now;
        rst = r; new_frame = nf; cfg_wr = wr; cfg_mask = cfg;
        raw_de = de; raw_hsync = hs; raw_vsync = vs;
        layer_pe = pe; bg_color = bg; layer_color = col;

        e.target = cyc + 1;
        if (r || prev.rst) begin
            e.hs = 1'b0; e.vs = 1'b0; e.de = 1'b0; e.rgb = '0; e.hit = 4'hF;
        end else begin
            e.hs = prev.hs; e.vs = prev.vs; e.de = prev.de;
            e.rgb = '0; e.hit = 4'hF;
            if (prev.de) begin
                e.rgb = prev.bg;
                for (int i = NL - 1; i >= 0; i--) begin
                    if (prev.pe_m[i]) begin
                        e.rgb = prev.col[i*CW +: CW];
                        e.hit = 4'(i);
                        break;
                    end
                end
            end
        end

        masked  = pe & m_active;
        hit_now = de && (masked[1] && masked[2]);
`ifdef COMPOSITOR_COLLISION_EN
        e.coll = !r && nf && m_accum;
`else
        e.coll = 1'b0;
`endif
        if (e.coll) coll_pulses_expected++;

        if (r) begin
            m_active = '1; m_pending = '1; m_accum = 1'b0;
        end else begin
            if (nf) m_active = wr ? cfg : m_pending;
            if (wr) m_pending = cfg;
            m_accum = nf ? hit_now : (m_accum | hit_now);
        end

        cur.rst = r; cur.hs = hs; cur.vs = vs; cur.de = de; cur.bg = bg; cur.pe_m = masked; cur.col = col;
        prev = cur;
        exp_q.push_back(e);
        @(posedge clk);
        #1;
    endtask

    function automatic logic [NL*CW-1:0] randColors();
        logic [NL*CW-1:0] c;
        for (int i = 0; i < NL; i++) c[i*CW +: CW] = CW'($urandom);
        return c;
    endfunction

    initial begin
        #2_000_000;
        $display("[TB] FAIL timeout: got no finish, expected end of run");
        $fatal(1, "[TB] timeout");
    end

    initial begin
        logic [NL*CW-1:0] cols;
        cols = '0;
        cols[1*CW +: CW] = 16'h07E0;
        cols[2*CW +: CW] = 16'hF800;
        cols[7*CW +: CW] = 16'h001F;

        repeat (3) applyStimulus(1, 0, 0, 8'h00, 0, 0, 0, 8'h00, 16'h0000, '0);
        applyStimulus(0, 1, 0, 8'h00, 0, 1, 1, 8'h00, 16'h0000, '0);

        // Priority: layers 1 and 2 paint, layer 2 wins; then background and blanking.
        applyStimulus(0, 0, 0, 8'h00, 1, 0, 0, 8'h06, 16'h1234, cols);
        applyStimulus(0, 0, 0, 8'h00, 1, 1, 0, 8'h00, 16'h5D7F, cols);
        applyStimulus(0, 0, 0, 8'h00, 0, 0, 1, 8'h86, 16'h5D7F, cols);
        applyStimulus(0, 0, 0, 8'h00, 1, 0, 0, 8'h86, 16'h5D7F, cols);

        // Mask write mid-frame disables layer 2 only after the next new_frame.
        applyStimulus(0, 0, 1, 8'hFB, 1, 0, 0, 8'h04, 16'h5D7F, cols);
        repeat (3) applyStimulus(0, 0, 0, 8'h00, 1, 0, 0, 8'h04, 16'h5D7F, cols);
        applyStimulus(0, 1, 0, 8'h00, 1, 0, 0, 8'h04, 16'h5D7F, cols);
        repeat (2) applyStimulus(0, 0, 0, 8'h00, 1, 0, 0, 8'h04, 16'h5D7F, cols);
        // Write coinciding with new_frame bypasses pending; two writes leave the last one.
        applyStimulus(0, 1, 1, 8'hFF, 1, 0, 0, 8'h04, 16'h5D7F, cols);
        applyStimulus(0, 0, 1, 8'h00, 1, 0, 0, 8'h04, 16'h5D7F, cols);
        applyStimulus(0, 0, 1, 8'hFF, 1, 0, 0, 8'h04, 16'h5D7F, cols);
        applyStimulus(0, 1, 0, 8'h00, 1, 0, 0, 8'h06, 16'h5D7F, cols);

        // Collision in frame N, none in frame N+1.
        applyStimulus(0, 0, 0, 8'h00, 1, 0, 0, 8'h06, 16'h5D7F, cols);
        repeat (3) applyStimulus(0, 0, 0, 8'h00, 1, 0, 0, 8'h02, 16'h5D7F, cols);
        applyStimulus(0, 1, 0, 8'h00, 1, 0, 0, 8'h00, 16'h5D7F, cols);
        repeat (4) applyStimulus(0, 0, 0, 8'h00, 1, 0, 0, 8'h04, 16'h5D7F, cols);
        applyStimulus(0, 1, 0, 8'h00, 0, 0, 0, 8'h06, 16'h5D7F, cols);
        repeat (2) applyStimulus(0, 0, 0, 8'h00, 1, 0, 0, 8'h00, 16'h5D7F, cols);

        // Reset mid-frame after a hit and a pending write: no pulse, mask write dropped.
        applyStimulus(0, 0, 1, 8'h00, 1, 0, 0, 8'h06, 16'h5D7F, cols);
        repeat (2) applyStimulus(1, 0, 0, 8'h00, 1, 1, 1, 8'h06, 16'h5D7F, cols);
        repeat (2) applyStimulus(0, 0, 0, 8'h00, 0, 0, 0, 8'h00, 16'h5D7F, cols);
        applyStimulus(0, 1, 0, 8'h00, 1, 0, 0, 8'h80, 16'h5D7F, cols);
        repeat (3) applyStimulus(0, 0, 0, 8'h00, 1, 0, 0, 8'h86, 16'h5D7F, cols);

        for (int n = 0; n < 3000; n++) begin
            applyStimulus(($urandom_range(0, 399) == 0), ($urandom_range(0, 47) == 0),
                          ($urandom_range(0, 19) == 0), NL'($urandom),
                          ($urandom_range(0, 3) != 0), 1'($urandom), 1'($urandom),
                          NL'($urandom & $urandom), CW'($urandom), randColors());
        end
        repeat (3) applyStimulus(0, 0, 0, 8'h00, 0, 0, 0, 8'h00, 16'h0000, '0);

        repeat (3) @(negedge clk);
        checks_total++;
        if (exp_q.size() == 0) checks_passed++;
        else $display("[TB] FAIL scoreboard_drain: got %0d entries left, expected 0", exp_q.size());
        $display("[TB] expected collision pulses: %0d", coll_pulses_expected);
        $display("%0d/%0d checks passed", checks_passed, checks_total);
        $finish;
    end

endmodule
